cbus_mem_responder: RTL and testbench



---
 rtl/cbus_mem_responder_pkg.sv | 41 ++++
 rtl/cbus_mem_responder_if.sv | 11 +
 rtl/cbus_ram_array.sv | 33 +++
 rtl/cbus_mem_responder.sv | 157 +++++++++++++++
 tb/tb_cbus_mem_responder.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cbus_mem_responder_pkg.sv
// Shared CBus types for the memory responder: request/response structs,
// burst encodings, beat-length type and the responder FSM state enum.
package cbus_mem_responder_pkg;

    localparam int CBUS_ADDR_W = 64;
    localparam int CBUS_DATA_W = 64;
    localparam int CBUS_STRB_W = CBUS_DATA_W / 8;
    localparam int CBUS_LEN_W  = 8;

    // Burst encodings follow AXI; WRAP is not supported and behaves as INCR.
    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    // Number of beats minus one.
    typedef logic [CBUS_LEN_W-1:0] cbus_len_t;

    typedef struct packed {
        logic                   valid;
        logic                   is_write;
        logic [2:0]             size;
        logic [CBUS_ADDR_W-1:0] addr;
        logic [CBUS_STRB_W-1:0] strobe;
        logic [CBUS_DATA_W-1:0] data;
        cbus_len_t              len;
        logic [1:0]             burst;
    } cbus_req_t;

    typedef struct packed {
        logic                   ready;
        logic                   last;
        logic [CBUS_DATA_W-1:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } cbus_resp_state_t;

endpackage

// File: rtl/cbus_mem_responder_if.sv
// CBus request/response bundle between an initiator (master) and the
// memory responder (slave).
interface cbus_mem_responder_if;
    import cbus_mem_responder_pkg::*;

    cbus_req_t  creq;
    cbus_resp_t cresp;

    modport master (output creq, input cresp);
    modport slave  (input creq, output cresp);
endinterface

// File: rtl/cbus_ram_array.sv
// Single-port MEM_WORDS x 64 RAM built from eight byte-wide lanes so each
// byte enable maps onto its own inferred block RAM. Read is registered
// (read-first): the address presented in cycle N shows data in cycle N+1.
module cbus_ram_array #(
    parameter int MEM_WORDS = 65536,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_we,
    input  logic [63:0]       i_wdata,
    output logic [63:0]       o_rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] r_mem [MEM_WORDS];
            logic [7:0] r_q;

            // Byte-lane write plus registered read of the same address.
            always_ff @(posedge clk) begin
                if (i_we[gi]) begin
                    r_mem[i_addr] <= i_wdata[gi*8 +: 8];
                end
                r_q <= r_mem[i_addr];
            end

            assign o_rdata[gi*8 +: 8] = r_q;
        end
    endgenerate

endmodule

// File: rtl/cbus_mem_responder.sv
// CBus memory responder: accepts single/INCR/FIXED bursts, waits a fixed
// LATENCY, then returns one beat per cycle from an internal word RAM.
// Reads prefetch the next beat's word one cycle early so data lines up with
// ready; writes commit on the edge that ends each ready cycle.
module cbus_mem_responder
    import cbus_mem_responder_pkg::*;
#(
    parameter int          MEM_WORDS = 65536,
    parameter int          LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    cbus_mem_responder_if.slave  cbus
);

    localparam int          AW   = $clog2(MEM_WORDS);
    localparam int          LW   = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam logic [63:0] SPAN = 64'(MEM_WORDS) << 3;

    cbus_resp_state_t r_state;
    cbus_len_t        r_beat;
    cbus_len_t        r_len;
    logic [LW-1:0]    r_lat;
    logic             r_is_write;
    logic             r_fixed;
    logic             r_in_range;
    logic [AW-1:0]    r_base_idx;
    logic             r_ready;
    logic             r_last;

    logic [63:0]      w_offset;
    logic             w_req_in_range;
    logic [AW-1:0]    w_req_idx;
    logic [AW-1:0]    w_cur_idx;
    logic [AW-1:0]    w_next_idx;
    logic [AW-1:0]    w_ram_addr;
    logic [7:0]       w_ram_we;
    logic [63:0]      w_ram_rdata;
    cbus_resp_t       w_resp;
    logic             w_unused_size;

    // size carries no meaning here; strobe alone selects written bytes.
    assign w_unused_size = ^cbus.creq.size;

    // Range check is made once on the start address; beats then wrap
    // modulo MEM_WORDS.
    assign w_offset       = cbus.creq.addr - BASE_ADDR;
    assign w_req_in_range = (cbus.creq.addr >= BASE_ADDR) && (w_offset < SPAN);
    assign w_req_idx      = w_offset[AW+2:3];
    assign w_cur_idx      = r_fixed ? r_base_idx : (r_base_idx + AW'(r_beat));
    assign w_next_idx     = r_fixed ? r_base_idx : (w_cur_idx + AW'(1));

    // RAM port steering: reads look one word ahead, writes use the current beat.
    always_comb begin
        w_ram_addr = r_base_idx;
        w_ram_we   = '0;
        case (r_state)
            IDLE: w_ram_addr = w_req_idx;
            BURST: begin
                if (r_is_write) begin
                    w_ram_addr = w_cur_idx;
                    if (r_in_range && !reset) begin
                        w_ram_we = cbus.creq.strobe;
                    end
                end else begin
                    w_ram_addr = w_next_idx;
                end
            end
            default: w_ram_addr = r_base_idx;
        endcase
    end

    cbus_ram_array #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (AW)
    ) u_ram (
        .clk     (clk),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_wdata (cbus.creq.data),
        .o_rdata (w_ram_rdata)
    );

    // Response bundle: read data only during in-range read beats, else zero.
    always_comb begin
        w_resp       = '0;
        w_resp.ready = r_ready;
        w_resp.last  = r_last;
        if (r_ready && !r_is_write && r_in_range) begin
            w_resp.data = w_ram_rdata;
        end
    end

    assign cbus.cresp = w_resp;

    // Responder FSM with registered ready/last.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_beat     <= '0;
            r_len      <= '0;
            r_lat      <= '0;
            r_is_write <= 1'b0;
            r_fixed    <= 1'b0;
            r_in_range <= 1'b0;
            r_base_idx <= '0;
            r_ready    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cbus.creq.valid) begin
                        r_is_write <= cbus.creq.is_write;
                        r_fixed    <= (cbus.creq.burst == AXI_BURST_FIXED);
                        r_len      <= cbus.creq.len;
                        r_base_idx <= w_req_idx;
                        r_in_range <= w_req_in_range;
                        r_beat     <= '0;
                        r_lat      <= LW'(LATENCY);
                        if (LATENCY > 0) begin
                            r_state <= WAIT;
                        end else begin
                            r_state <= BURST;
                            r_ready <= 1'b1;
                            r_last  <= (cbus.creq.len == '0);
                        end
                    end
                end
                WAIT: begin
                    r_lat <= r_lat - LW'(1);
                    if (r_lat <= LW'(1)) begin
                        r_state <= BURST;
                        r_ready <= 1'b1;
                        r_last  <= (r_len == '0);
                    end
                end
                BURST: begin
                    if (r_last) begin
                        r_state <= DONE;
                        r_ready <= 1'b0;
                        r_last  <= 1'b0;
                    end else begin
                        r_beat <= r_beat + 8'd1;
                        r_last <= ((r_beat + 8'd1) == r_len);
                    end
                end
                DONE: begin
                    // Held valid from the finished transaction is ignored here.
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Bench for cbus_mem_responder: two instances (LATENCY=2 and LATENCY=0),
// a bench-side memory model, and a queue of expected beats checked as the
// responder produces them.
module tb_cbus_mem_responder;
    import cbus_mem_responder_pkg::*;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          W_A   = 65536;
    localparam int          W_B   = 1024;
    localparam int          LAT_A = 2;
    localparam int          LAT_B = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cbus_mem_responder_if bus_a();
    cbus_mem_responder_if bus_b();

    cbus_mem_responder #(.MEM_WORDS(W_A), .LATENCY(LAT_A), .BASE_ADDR(BASE)) dut_a (
        .clk(clk), .reset(reset), .cbus(bus_a)
    );
    cbus_mem_responder #(.MEM_WORDS(W_B), .LATENCY(LAT_B), .BASE_ADDR(BASE)) dut_b (
        .clk(clk), .reset(reset), .cbus(bus_b)
    );

    typedef struct {
        bit          w;
        logic [63:0] data;
        bit          last;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] mdl_a[int];
    logic [63:0] mdl_b[int];
    logic [63:0] wdat[16];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int widx(input bit sel, input logic [63:0] addr, input int b);
        logic [63:0] off;
        off = ((addr - BASE) >> 3) + 64'(b);
        return int'(off % 64'(sel ? W_B : W_A));
    endfunction

    function automatic bit in_range(input bit sel, input logic [63:0] addr);
        logic [63:0] span;
        span = 64'(sel ? W_B : W_A) * 64'd8;
        return (addr >= BASE) && ((addr - BASE) < span);
    endfunction

    function automatic logic [63:0] mdl_rd(input bit sel, input int idx);
        if (sel) return mdl_b.exists(idx) ? mdl_b[idx] : 64'hx;
        return mdl_a.exists(idx) ? mdl_a[idx] : 64'hx;
    endfunction

    task automatic mdl_wr(input bit sel, input int idx, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] v;
        v = mdl_rd(sel, idx);
        for (int k = 0; k < 8; k++) if (s[k]) v[k*8 +: 8] = d[k*8 +: 8];
        if (sel) mdl_b[idx] = v; else mdl_a[idx] = v;
    endtask

    task automatic drive(input bit sel, input cbus_req_t r);
        if (sel) bus_b.creq = r; else bus_a.creq = r;
    endtask

    function automatic cbus_resp_t get_resp(input bit sel);
        return sel ? bus_b.cresp : bus_a.cresp;
    endfunction

    task automatic mon(input string who, input cbus_resp_t r);
        exp_t e;
        $display("beat %s last=%0d data=%h", who, r.last, r.data);
        if (exp_q.size() == 0) begin
            check("spurious_beat", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("beat_last", 64'(r.last), 64'(e.last));
            if (!e.w) check("beat_data", r.data, e.data);
        end
    endtask

    // Scoreboard consumer: every ready beat must match the next queued entry.
    always @(negedge clk) begin
        if (bus_a.cresp.ready === 1'b1) mon("a", bus_a.cresp);
        if (bus_b.cresp.ready === 1'b1) mon("b", bus_b.cresp);
    end

    // One full transaction; returns one cycle after the last beat with valid dropped.
    task automatic txn(input bit sel, input bit w, input logic [63:0] addr, input int len,
                       input logic [1:0] burst, input logic [7:0] strb, input int exp_first);
        cbus_req_t  r;
        cbus_resp_t rs;
        exp_t       e;
        bit         inr;
        int         idx;
        int         cyc;
        int         beats;
        bit         got_last;
        inr = in_range(sel, addr);
        for (int b = 0; b <= len; b++) begin
            idx = widx(sel, addr, (burst == AXI_BURST_FIXED) ? 0 : b);
            e.w = w;
            e.last = (b == len);
            e.data = '0;
            if (w) begin
                if (inr) mdl_wr(sel, idx, wdat[b], strb);
            end else begin
                e.data = inr ? mdl_rd(sel, idx) : 64'd0;
            end
            exp_q.push_back(e);
        end
        $display("txn dut=%0d %s addr=%h len=%0d burst=%0d strb=%h", sel, w ? "WR" : "RD",
                 addr, len, burst, strb);
        r = '0;
        r.valid = 1'b1; r.is_write = w; r.size = 3'd3; r.addr = addr; r.strobe = strb;
        r.data = w ? wdat[0] : 64'd0; r.len = cbus_len_t'(len); r.burst = burst;
        drive(sel, r);
        cyc = 0; beats = 0; got_last = 1'b0;
        while (!got_last && cyc < 64) begin
            @(negedge clk);
            rs = get_resp(sel);
            if (rs.ready === 1'b1) begin
                if (beats == 0) check("first_lat", 64'(cyc), 64'(exp_first));
                beats++;
                got_last = rs.last;
            end
            cyc++;
            @(posedge clk); #1;
            if (rs.ready === 1'b1 && !rs.last && w) begin
                r.data = wdat[beats];
                drive(sel, r);
            end
        end
        if (!got_last) check("timeout", 64'd0, 64'd1);
        check("beat_count", 64'(beats), 64'(len + 1));
        r.valid = 1'b0;
        drive(sel, r);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            check("idle_rdy_a", 64'(bus_a.cresp.ready), 64'd0);
            check("idle_rdy_b", 64'(bus_b.cresp.ready), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    // Write of 4 beats interrupted by reset during beat 2.
    task automatic reset_mid_burst(input logic [63:0] addr);
        cbus_req_t r;
        exp_t      e;
        int        beats;
        int        cyc;
        bit        rdy;
        for (int b = 0; b < 3; b++) begin
            e.w = 1'b1; e.last = 1'b0; e.data = '0;
            exp_q.push_back(e);
            if (b < 2) mdl_wr(1'b0, widx(1'b0, addr, b), wdat[b], 8'hFF);
        end
        $display("txn dut=0 WR addr=%h len=3 with reset at beat 2", addr);
        r = '0;
        r.valid = 1'b1; r.is_write = 1'b1; r.size = 3'd3; r.addr = addr; r.strobe = 8'hFF;
        r.data = wdat[0]; r.len = 8'd3; r.burst = AXI_BURST_INCR;
        drive(1'b0, r);
        beats = 0; cyc = 0;
        while (beats < 2 && cyc < 20) begin
            @(negedge clk);
            rdy = (bus_a.cresp.ready === 1'b1);
            if (rdy) beats++;
            cyc++;
            @(posedge clk); #1;
            if (rdy) begin
                r.data = wdat[beats];
                drive(1'b0, r);
            end
        end
        if (beats < 2) check("rst_timeout", 64'd0, 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        r.valid = 1'b0;
        drive(1'b0, r);
        @(negedge clk);
        check("rst_ready", 64'(bus_a.cresp.ready), 64'd0);
        check("rst_last", 64'(bus_a.cresp.last), 64'd0);
        check("rst_data", bus_a.cresp.data, 64'd0);
        check("rst_state", 64'(dut_a.r_state), 64'(IDLE));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.creq = '0;
        bus_b.creq = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready_a", 64'(bus_a.cresp.ready), 64'd0);
        check("reset_last_a", 64'(bus_a.cresp.last), 64'd0);
        check("reset_data_a", bus_a.cresp.data, 64'd0);
        check("reset_ready_b", 64'(bus_b.cresp.ready), 64'd0);
        check("reset_last_b", 64'(bus_b.cresp.last), 64'd0);
        check("reset_data_b", bus_b.cresp.data, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle(1);

        // Single write then read raised in the DONE cycle (one extra cycle).
        wdat[0] = 64'h1122_3344_5566_7788;
        txn(1'b0, 1'b1, 64'h8000_0010, 0, AXI_BURST_INCR, 8'hFF, LAT_A + 1);
        txn(1'b0, 1'b0, 64'h8000_0010, 0, AXI_BURST_INCR, 8'hFF, LAT_A + 2);
        idle(1);

        // Partial strobe over an all-ones word.
        wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        txn(1'b0, 1'b1, 64'h8000_0020, 0, AXI_BURST_INCR, 8'hFF, LAT_A + 1);
        idle(1);
        wdat[0] = 64'h0;
        txn(1'b0, 1'b1, 64'h8000_0020, 0, AXI_BURST_INCR, 8'h0F, LAT_A + 1);
        idle(1);
        txn(1'b0, 1'b0, 64'h8000_0020, 0, AXI_BURST_INCR, 8'hFF, LAT_A + 1);
        idle(1);

        // INCR burst of 4, then back-to-back read after one idle cycle.
        for (int i = 0; i < 4; i++) wdat[i] = 64'(i);
        txn(1'b0, 1'b1, 64'h8000_0100, 3, AXI_BURST_INCR, 8'hFF, LAT_A + 1);
        idle(1);
        txn(1'b0, 1'b0, 64'h8000_0100, 3, AXI_BURST_INCR, 8'hFF, LAT_A + 1);
        idle(1);
        txn(1'b0, 1'b0, 64'h8000_0100, 3, AXI_BURST_INCR, 8'hFF, LAT_A + 1);
        idle(2);

        // LATENCY=0 instance: in-range, out-of-range, aliasing and FIXED.
        wdat[0] = 64'h5A5A_A5A5_0123_4567;
        txn(1'b1, 1'b1, 64'h8000_0040, 0, AXI_BURST_INCR, 8'hFF, LAT_B + 1);
        idle(1);
        txn(1'b1, 1'b0, 64'h8000_0040, 0, AXI_BURST_INCR, 8'hFF, LAT_B + 1);
        idle(1);
        wdat[0] = 64'hC3C3_C3C3_3C3C_3C3C;
        txn(1'b1, 1'b1, 64'h8000_1000, 0, AXI_BURST_INCR, 8'hFF, LAT_B + 1);
        idle(1);
        txn(1'b1, 1'b0, 64'h0000_1000, 0, AXI_BURST_INCR, 8'hFF, LAT_B + 1);
        idle(1);
        wdat[0] = 64'hDEAD_BEEF_DEAD_BEEF;
        txn(1'b1, 1'b1, 64'h0000_1000, 0, AXI_BURST_INCR, 8'hFF, LAT_B + 1);
        idle(1);
        txn(1'b1, 1'b0, 64'h8000_1000, 0, AXI_BURST_INCR, 8'hFF, LAT_B + 1);
        idle(1);
        txn(1'b1, 1'b0, 64'h8000_0040, 0, AXI_BURST_INCR, 8'hFF, LAT_B + 1);
        idle(1);
        txn(1'b1, 1'b0, 64'h8000_2000, 0, AXI_BURST_INCR, 8'hFF, LAT_B + 1);
        idle(1);
        wdat[0] = 64'd7; wdat[1] = 64'd8; wdat[2] = 64'd9;
        txn(1'b1, 1'b1, 64'h8000_0080, 2, AXI_BURST_FIXED, 8'hFF, LAT_B + 1);
        idle(1);
        txn(1'b1, 1'b0, 64'h8000_0080, 0, AXI_BURST_INCR, 8'hFF, LAT_B + 1);
        txn(1'b1, 1'b0, 64'h8000_0088, 0, AXI_BURST_INCR, 8'hFF, LAT_B + 2);
        idle(1);

        // Reset mid-burst: beats 0-1 persist, beats 2-3 keep preloaded values.
        for (int i = 0; i < 4; i++) wdat[i] = 64'hAAAA_0000_0000_0000 + 64'(i);
        txn(1'b0, 1'b1, 64'h8000_0200, 3, AXI_BURST_INCR, 8'hFF, LAT_A + 1);
        idle(1);
        for (int i = 0; i < 4; i++) wdat[i] = 64'hBBBB_0000_0000_0000 + 64'(i);
        reset_mid_burst(64'h8000_0200);
        idle(1);
        txn(1'b0, 1'b0, 64'h8000_0200, 3, AXI_BURST_INCR, 8'hFF, LAT_A + 1);
        idle(2);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
